multicycle_controller: RTL and testbench

- Main control unit of the multi-cycle RV32I core.
- Sequences the shared datapath registers (PC, OldPC, IR, Data, A/B, ALUOut) and the single ALU/memory port through a Moore FSM, one phase per clock.
- Also contains the immediate-type decoder and the ALU decoder.
- Consumes the IR opcode/funct fields and the ALU zero flag. Drives every enable and mux select in the datapath.

---
 rtl/multicycle_controller.sv | 261 ++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Main control unit of the multi-cycle RV32I core. A Moore FSM steps the
// shared datapath (PC, OldPC, IR, Data, A/B, ALUOut) and the single ALU /
// memory port through one phase per clock. The block also contains the
// immediate-type decoder and the ALU decoder.
//
// Ports:
//   clk         in   clock, state advances on posedge
//   reset       in   asynchronous active-high reset, forces FETCH
//   op          in   IR[6:0] opcode
//   funct3      in   IR[14:12]
//   funct7b5    in   IR[30]
//   zero        in   ALU zero flag (combinational from the datapath)
//   pc_write    out  PC enable = pc_update | (branch & zero)
//   adr_src     out  memory address select: 0=PC, 1=Result
//   mem_write   out  memory write enable
//   ir_write    out  IR and OldPC enable
//   result_src  out  00=ALUOut, 01=Data, 10=ALUResult
//   alu_src_a   out  00=PC, 01=OldPC, 10=A
//   alu_src_b   out  00=B, 01=ImmExt, 10=constant 4
//   imm_src     out  00=I, 01=S, 10=B, 11=J (decoded from op only)
//   alu_control out  000 add, 001 sub, 010 and, 011 or, 101 slt
//   reg_write   out  register file write enable
// ---------------------------------------------------------------------------
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       reg_write
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  // Moore control word; every field is a function of the state alone.
  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;
    logic       reg_write;
  } ctrl_t;

  // Control word for a given state. Encodings outside the enum give all zeros.
  function automatic ctrl_t moore_ctrl(input state_t s);
    ctrl_t c;
    c = ctrl_t'(14'd0);
    case (s)
      S_FETCH: begin
        c.adr_src    = 1'b0;
        c.ir_write   = 1'b1;
        c.alu_src_a  = 2'b00;
        c.alu_src_b  = 2'b10;
        c.alu_op     = 2'b00;
        c.result_src = 2'b10;
        c.pc_update  = 1'b1;
      end
      S_DECODE: begin
        // OldPC + ImmExt: branch target lands in ALUOut ahead of BEQ.
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b00;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b00;
      end
      S_MEMREAD: begin
        c.result_src = 2'b00;
        c.adr_src    = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.result_src = 2'b00;
        c.adr_src    = 1'b1;
        c.mem_write  = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b00;
        c.alu_op    = 2'b10;
      end
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.result_src = 2'b00;
        c.reg_write  = 1'b1;
      end
      S_JAL: begin
        // OldPC + 4 is the link value; ALUOut (jump target) goes to PC.
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.alu_op     = 2'b00;
        c.result_src = 2'b00;
        c.pc_update  = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a  = 2'b10;
        c.alu_src_b  = 2'b00;
        c.alu_op     = 2'b01;
        c.result_src = 2'b00;
        c.branch     = 1'b1;
      end
      default: begin
        c = ctrl_t'(14'd0);
      end
    endcase
    return c;
  endfunction

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;
  logic [2:0] alu_ctl_s;
  logic [1:0] imm_src_s;

  // Next-state logic.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_LW:   state_d = S_MEMADR;
          OP_SW:   state_d = S_MEMADR;
          OP_R:    state_d = S_EXECR;
          OP_IALU: state_d = S_EXECI;
          OP_JAL:  state_d = S_JAL;
          OP_BEQ:  state_d = S_BEQ;
          default: state_d = S_FETCH;  // unsupported opcode behaves as a NOP
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW) begin
          state_d = S_MEMREAD;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register plus the control word registered from the next state,
  // so outputs are flop-driven yet still match the current state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= moore_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= moore_ctrl(state_d);
    end
  end

  // ALU decoder: alu_op from the state, refined by funct bits for ALU ops.
  always_comb begin
    alu_ctl_s = 3'b000;
    case (ctrl_q.alu_op)
      2'b00: alu_ctl_s = 3'b000;
      2'b01: alu_ctl_s = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000: begin
            // op[5] separates R-type from I-ALU; only R-type can subtract.
            if (op[5] & funct7b5) begin
              alu_ctl_s = 3'b001;
            end else begin
              alu_ctl_s = 3'b000;
            end
          end
          3'b010:  alu_ctl_s = 3'b101;
          3'b110:  alu_ctl_s = 3'b011;
          3'b111:  alu_ctl_s = 3'b010;
          default: alu_ctl_s = 3'b000;
        endcase
      end
      default: alu_ctl_s = 3'b000;
    endcase
  end

  // Immediate-type decoder, driven from the opcode only.
  always_comb begin
    imm_src_s = 2'b00;
    case (op)
      OP_LW:   imm_src_s = 2'b00;
      OP_IALU: imm_src_s = 2'b00;
      OP_SW:   imm_src_s = 2'b01;
      OP_BEQ:  imm_src_s = 2'b10;
      OP_JAL:  imm_src_s = 2'b11;
      default: imm_src_s = 2'b00;
    endcase
  end

  // zero is sampled combinationally so BEQ resolves in its own cycle.
  assign pc_write    = ctrl_q.pc_update | (ctrl_q.branch & zero);
  assign adr_src     = ctrl_q.adr_src;
  assign mem_write   = ctrl_q.mem_write;
  assign ir_write    = ctrl_q.ir_write;
  assign result_src  = ctrl_q.result_src;
  assign alu_src_a   = ctrl_q.alu_src_a;
  assign alu_src_b   = ctrl_q.alu_src_b;
  assign imm_src     = imm_src_s;
  assign alu_control = alu_ctl_s;
  assign reg_write   = ctrl_q.reg_write;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for multicycle_controller. Each cycle the full output set is
// packed into one 16-bit word and compared against a hand-written expected
// word:
//   {pc_write, adr_src, mem_write, ir_write, result_src[1:0], alu_src_a[1:0],
//    alu_src_b[1:0], imm_src[1:0], alu_control[2:0], reg_write}
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       reg_write;

  int pass_cnt;
  int total_cnt;

  multicycle_controller dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .reg_write   (reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, imm_src, alu_control, reg_write};

  // Pack one expected output word.
  function automatic logic [15:0] ev(input logic pcw, input logic adr,
                                     input logic mw, input logic irw,
                                     input logic [1:0] rs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] imm,
                                     input logic [2:0] aluc, input logic rw);
    return {pcw, adr, mw, irw, rs, a, b, imm, aluc, rw};
  endfunction

  // Common per-state words; imm depends on the opcode being driven.
  function automatic logic [15:0] fetch_v(input logic [1:0] imm);
    return ev(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, imm, 3'b000, 1'b0);
  endfunction

  function automatic logic [15:0] decode_v(input logic [1:0] imm);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 1'b0);
  endfunction

  function automatic logic [15:0] aluwb_v(input logic [1:0] imm);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1'b1);
  endfunction

  function automatic logic [15:0] execr_v(input logic [2:0] aluc);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, aluc, 1'b0);
  endfunction

  function automatic logic [15:0] execi_v(input logic [2:0] aluc);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, aluc, 1'b0);
  endfunction

  // Single comparison point.
  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Check the current cycle, then advance to the next falling edge.
  task automatic cyc(input string tag, input logic [15:0] exp);
    #1;
    check(tag, obs, exp);
    @(negedge clk);
  endtask

  task automatic set_ir(input logic [6:0] o, input logic [2:0] f3,
                        input logic f7, input logic z);
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    zero     = z;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    set_ir(7'b0000011, 3'b010, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset release, then lw up to MEMREAD
    cyc("rst_fetch", fetch_v(2'b00));
    cyc("rst_decode", decode_v(2'b00));
    cyc("lw0_memadr", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0));
    #1;
    check("lw0_memread", obs, ev(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));

    // Asynchronous reset mid-MEMREAD, held for two cycles
    reset = 1'b1;
    #1;
    check("rst_async", obs, fetch_v(2'b00));
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_held", obs, fetch_v(2'b00));
    reset = 1'b0;
    @(negedge clk);
    // Still FETCH: the first edge after reset release leaves FETCH? No -- the
    // edge after release moves FETCH to DECODE, so this cycle is DECODE.
    cyc("rst_rel_decode", decode_v(2'b00));

    // Full lw from FETCH
    cyc("lw_memadr_pre", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0));
    cyc("lw_memread_pre", ev(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
    cyc("lw_memwb_pre", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));
    cyc("lw_fetch", fetch_v(2'b00));
    cyc("lw_decode", decode_v(2'b00));
    cyc("lw_memadr", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0));
    cyc("lw_memread", ev(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
    cyc("lw_memwb", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));

    // sw
    set_ir(7'b0100011, 3'b010, 1'b0, 1'b0);
    cyc("sw_fetch", fetch_v(2'b01));
    cyc("sw_decode", decode_v(2'b01));
    cyc("sw_memadr", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000, 1'b0));
    cyc("sw_memwrite", ev(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0));

    // R-type sub
    set_ir(7'b0110011, 3'b000, 1'b1, 1'b0);
    cyc("rsub_fetch", fetch_v(2'b00));
    cyc("rsub_decode", decode_v(2'b00));
    cyc("rsub_execr", execr_v(3'b001));
    cyc("rsub_aluwb", aluwb_v(2'b00));

    // I-ALU with the same funct bits adds
    set_ir(7'b0010011, 3'b000, 1'b1, 1'b0);
    cyc("iadd_fetch", fetch_v(2'b00));
    cyc("iadd_decode", decode_v(2'b00));
    cyc("iadd_execi", execi_v(3'b000));
    cyc("iadd_aluwb", aluwb_v(2'b00));

    // R-type or
    set_ir(7'b0110011, 3'b110, 1'b0, 1'b0);
    cyc("ror_fetch", fetch_v(2'b00));
    cyc("ror_decode", decode_v(2'b00));
    cyc("ror_execr", execr_v(3'b011));
    cyc("ror_aluwb", aluwb_v(2'b00));

    // R-type slt
    set_ir(7'b0110011, 3'b010, 1'b0, 1'b0);
    cyc("rslt_fetch", fetch_v(2'b00));
    cyc("rslt_decode", decode_v(2'b00));
    cyc("rslt_execr", execr_v(3'b101));
    cyc("rslt_aluwb", aluwb_v(2'b00));

    // I-ALU and
    set_ir(7'b0010011, 3'b111, 1'b0, 1'b0);
    cyc("iand_fetch", fetch_v(2'b00));
    cyc("iand_decode", decode_v(2'b00));
    cyc("iand_execi", execi_v(3'b010));
    cyc("iand_aluwb", aluwb_v(2'b00));

    // beq taken
    set_ir(7'b1100011, 3'b000, 1'b0, 1'b1);
    cyc("beqt_fetch", fetch_v(2'b10));
    cyc("beqt_decode", decode_v(2'b10));
    cyc("beqt_beq", ev(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b0));

    // beq not taken
    set_ir(7'b1100011, 3'b000, 1'b0, 1'b0);
    cyc("beqn_fetch", fetch_v(2'b10));
    cyc("beqn_decode", decode_v(2'b10));
    cyc("beqn_beq", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1'b0));

    // jal
    set_ir(7'b1101111, 3'b000, 1'b0, 1'b0);
    cyc("jal_fetch", fetch_v(2'b11));
    cyc("jal_decode", decode_v(2'b11));
    cyc("jal_jal", ev(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 1'b0));
    cyc("jal_aluwb", aluwb_v(2'b11));

    // Unsupported opcode: DECODE then straight back to FETCH
    set_ir(7'b0000000, 3'b000, 1'b0, 1'b0);
    cyc("nop_fetch", fetch_v(2'b00));
    cyc("nop_decode", decode_v(2'b00));
    cyc("nop_refetch", fetch_v(2'b00));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
